// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit: operation codes,
// exception codes, FSM states and the byte-lane/alignment helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    OpNone = 4'd0,
    OpLb   = 4'd1,
    OpLbu  = 4'd2,
    OpLh   = 4'd3,
    OpLhu  = 4'd4,
    OpLw   = 4'd5,
    OpSb   = 4'd6,
    OpSh   = 4'd7,
    OpSw   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ExcNone   = 2'd0,
    ExcAdel   = 2'd1,
    ExcAdes   = 2'd2,
    ExcBuserr = 2'd3
  } exc_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBus  = 1'b1
  } lsu_state_e;

  localparam int unsigned NumLanes = 4;
  localparam int unsigned LaneW    = 8;

  localparam logic [1:0] HalfAlignMask = 2'b01;
  localparam logic [1:0] WordAlignMask = 2'b11;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Registered MEM->WB result.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    exc_e        exc;
  } wb_t;

  // Instruction held while its bus transaction is outstanding.
  typedef struct packed {
    mem_op_e     op;
    logic [1:0]  off;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } pend_t;

  function automatic logic is_load(mem_op_e op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic logic is_mem(mem_op_e op);
    return is_load(op) | is_store(op);
  endfunction

  function automatic logic misaligned(mem_op_e op, logic [1:0] off);
    case (op)
      OpLh, OpLhu, OpSh: return |(off & HalfAlignMask);
      OpLw, OpSw:        return |(off & WordAlignMask);
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication, and
// load lane extraction with sign/zero extension. Lanes are little-endian.
module lsu_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Bring the addressed lane down to bit 0; alignment was checked upstream.
  assign shifted   = rdata >> {offset, 3'b000};
  assign lane_byte = shifted[LaneW-1:0];
  assign lane_half = shifted[2*LaneW-1:0];

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    case (op)
      OpSb: begin
        be    = BeByte << offset;
        wdata = {NumLanes{store_data[7:0]}};
      end
      OpSh: begin
        be    = BeHalf << offset;
        wdata = {(NumLanes / 2){store_data[15:0]}};
      end
      OpSw: begin
        be    = BeWord;
        wdata = store_data;
      end
      OpLb: begin
        be        = BeWord;
        load_data = {{24{lane_byte[7]}}, lane_byte};
      end
      OpLbu: begin
        be        = BeWord;
        load_data = {24'h0, lane_byte};
      end
      OpLh: begin
        be        = BeWord;
        load_data = {{16{lane_half[15]}}, lane_half};
      end
      OpLhu: begin
        be        = BeWord;
        load_data = {16'h0, lane_half};
      end
      OpLw: begin
        be        = BeWord;
        load_data = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: forwards ALU results, runs one data-bus transaction per memory
// op with alignment checks and a bus timeout, and registers the WB-bound result.
module stage_mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       store_data,
  input  logic              we_hilo,
  input  logic [31:0]       hi,
  input  logic [31:0]       lo,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              out_valid,
  output logic              we_o,
  output logic [4:0]        waddr_o,
  output logic [31:0]       wdata_o,
  output logic              we_hilo_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic [1:0]        exc_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  lsu_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic bus_req_q, bus_req_d;
  logic bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0] bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  pend_t pend_q, pend_d;
  wb_t wb_q, wb_d;

  mem_op_e op_in;
  mem_op_e lane_op;
  logic [1:0] lane_off;
  logic [3:0] lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;
  logic [ADDR_W-1:0] word_addr;
  logic timeout_hit;

  assign op_in = mem_op_e'(mem_op);

  if (ADDR_W > 32) begin : g_addr_wide
    assign word_addr = {{(ADDR_W - 32){1'b0}}, wdata[31:2], 2'b00};
  end else if (ADDR_W == 32) begin : g_addr_exact
    assign word_addr = {wdata[31:2], 2'b00};
  end else begin : g_addr_narrow
    assign word_addr = {wdata[ADDR_W-1:2], 2'b00};
  end

  // One aligner serves both directions: incoming op for store setup, pending op for load return.
  assign lane_op  = (state_q == StBus) ? pend_q.op : op_in;
  assign lane_off = (state_q == StBus) ? pend_q.off : wdata[1:0];

  lsu_lane_align u_lane_align (
    .op        (lane_op),
    .offset    (lane_off),
    .store_data(store_data),
    .rdata     (bus_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    pend_d      = pend_q;
    wb_d        = wb_q;
    wb_d.valid   = 1'b0;
    wb_d.we      = 1'b0;
    wb_d.we_hilo = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem(op_in)) begin
            wb_d = '{valid: 1'b1, we: we, waddr: waddr, wdata: wdata,
                     we_hilo: we_hilo, hi: hi, lo: lo, exc: ExcNone};
          end else if (misaligned(op_in, wdata[1:0])) begin
            wb_d = '{valid: 1'b1, we: 1'b0, waddr: waddr, wdata: wdata,
                     we_hilo: 1'b0, hi: hi, lo: lo,
                     exc: is_store(op_in) ? ExcAdes : ExcAdel};
          end else begin
            state_d     = StBus;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store(op_in);
            bus_addr_d  = word_addr;
            bus_be_d    = lane_be;
            bus_wdata_d = lane_wdata;
            pend_d      = '{op: op_in, off: wdata[1:0], we: we, waddr: waddr, wdata: wdata,
                            we_hilo: we_hilo, hi: hi, lo: lo};
          end
        end
      end
      StBus: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (bus_ack) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          wb_d = '{valid: 1'b1, we: is_load(pend_q.op) & pend_q.we, waddr: pend_q.waddr,
                   wdata: is_load(pend_q.op) ? lane_load : pend_q.wdata,
                   we_hilo: pend_q.we_hilo, hi: pend_q.hi, lo: pend_q.lo, exc: ExcNone};
        end else if (timeout_hit) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          wb_d = '{valid: 1'b1, we: 1'b0, waddr: pend_q.waddr, wdata: pend_q.wdata,
                   we_hilo: pend_q.we_hilo, hi: pend_q.hi, lo: pend_q.lo, exc: ExcBuserr};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      pend_q      <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      pend_q      <= pend_d;
      wb_q        <= wb_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign out_valid = wb_q.valid;
  assign we_o      = wb_q.we;
  assign waddr_o   = wb_q.waddr;
  assign wdata_o   = wb_q.wdata;
  assign we_hilo_o = wb_q.we_hilo;
  assign hi_o      = wb_q.hi;
  assign lo_o      = wb_q.lo;
  assign exc_o     = wb_q.exc;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: directed scenarios plus randomized transactions checked
// against an arithmetic reference model of the lane, alignment and timeout rules.
module tb_stage_mem_lsu;

  localparam int unsigned TO = 4;

  localparam int unsigned NONE = 0, LB = 1, LBU = 2, LH = 3, LHU = 4, LW = 5;
  localparam int unsigned SB = 6, SH = 7, SW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  mem_op;
  logic [31:0] store_data;
  logic        we_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        out_valid;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        we_hilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  exc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_mem_lsu #(
    .ADDR_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .mem_op    (mem_op),
    .store_data(store_data),
    .we_hilo   (we_hilo),
    .hi        (hi),
    .lo        (lo),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .out_valid (out_valid),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .we_hilo_o (we_hilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .exc_o     (exc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for non-memory ops.
  function automatic int unsigned m_size(int unsigned op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  function automatic bit m_is_store(int unsigned op);
    return op >= SB && op <= SW;
  endfunction

  function automatic logic [31:0] m_be(int unsigned op, logic [31:0] addr);
    int unsigned off = addr % 4;
    if (!m_is_store(op)) return 32'd15;
    if (m_size(op) == 1) return 32'd1 << off;
    if (m_size(op) == 2) return 32'd3 << off;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_store_word(int unsigned op, logic [31:0] sd);
    if (m_size(op) == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (m_size(op) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(int unsigned op, logic [31:0] addr, logic [31:0] rd);
    logic [31:0] v = rd >> (8 * (addr % 4));
    logic [31:0] b = v & 32'hFF;
    logic [31:0] h = v & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return rd;
    endcase
  endfunction

  // Issue one instruction, drive the bus per 'delay' (-1 = never ack) and check the result.
  task automatic run_txn(input int unsigned op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic we_i, input logic [4:0] wa, input logic wh,
                         input logic [31:0] h, input logic [31:0] l, input logic [31:0] rd,
                         input int delay);
    bit acked = 0;
    int cyc = 0;
    int unsigned sz = m_size(op);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; mem_op = op[3:0]; wdata = addr; store_data = sd; we = we_i;
    waddr = wa; we_hilo = wh; hi = h; lo = l;
    @(negedge clk);
    in_valid = 0;
    if (sz == 0) begin
      chk("alu_valid", out_valid, 1);
      chk("alu_we", we_o, we_i);
      chk("alu_waddr", waddr_o, wa);
      chk("alu_wdata", wdata_o, addr);
      chk("alu_we_hilo", we_hilo_o, wh);
      chk("alu_hi", hi_o, h);
      chk("alu_lo", lo_o, l);
      chk("alu_exc", exc_o, 0);
      chk("alu_no_bus", bus_req, 0);
    end else if (addr % sz != 0) begin
      chk("mis_valid", out_valid, 1);
      chk("mis_we", we_o, 0);
      chk("mis_we_hilo", we_hilo_o, 0);
      chk("mis_exc", exc_o, m_is_store(op) ? 2 : 1);
      chk("mis_no_bus", bus_req, 0);
      chk("mis_ready", in_ready, 1);
    end else begin
      while (!acked && cyc < int'(TO)) begin
        chk("bus_req", bus_req, 1);
        chk("busy_ready", in_ready, 0);
        chk("busy_valid", out_valid, 0);
        chk("bus_addr", bus_addr, addr & ~32'h3);
        chk("bus_be", bus_be, m_be(op, addr));
        chk("bus_we", bus_we, m_is_store(op));
        if (m_is_store(op)) chk("bus_wdata", bus_wdata, m_store_word(op, sd));
        if (cyc == delay) begin
          bus_ack = 1; bus_rdata = rd; acked = 1;
        end
        @(negedge clk);
        bus_ack = 0; bus_rdata = $urandom;
        if (!acked) cyc++;
      end
      chk("done_valid", out_valid, 1);
      chk("done_bus_req", bus_req, 0);
      chk("done_ready", in_ready, 1);
      chk("done_waddr", waddr_o, wa);
      chk("done_we_hilo", we_hilo_o, wh);
      chk("done_hi", hi_o, h);
      chk("done_lo", lo_o, l);
      if (acked) begin
        chk("done_exc", exc_o, 0);
        chk("done_we", we_o, m_is_store(op) ? 1'b0 : we_i);
        if (!m_is_store(op)) chk("load_data", wdata_o, m_load(op, addr, rd));
      end else begin
        chk("tmo_exc", exc_o, 3);
        chk("tmo_we", we_o, 0);
      end
    end
    @(negedge clk);
    chk("pulse_valid", out_valid, 0);
    chk("pulse_we", we_o, 0);
    chk("pulse_we_hilo", we_hilo_o, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; we = 0; waddr = '0; wdata = '0; mem_op = '0; store_data = '0;
    we_hilo = 0; hi = '0; lo = '0; bus_ack = 0; bus_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_we", we_o, 0);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_we_hilo", we_hilo_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_exc", exc_o, 0);
    rst = 0;

    run_txn(NONE, 32'h1234, 32'h0, 1, 5'd3, 0, 32'h0, 32'h0, 32'h0, 0);
    chk("alu_hold_wdata", wdata_o, 32'h1234);

    run_txn(LB, 32'h103, 32'h0, 1, 5'd4, 0, 32'h0, 32'h0, 32'h80FF_0000, 2);
    chk("lb_value", wdata_o, 32'hFFFF_FF80);
    run_txn(LBU, 32'h103, 32'h0, 1, 5'd4, 0, 32'h0, 32'h0, 32'h80FF_0000, 2);
    chk("lbu_value", wdata_o, 32'h0000_0080);

    run_txn(SH, 32'h102, 32'hABCD, 1, 5'd6, 1, 32'h11, 32'h22, 32'h0, 1);
    chk("sh_addr", bus_addr, 32'h100);
    chk("sh_be", bus_be, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);

    run_txn(LW, 32'h101, 32'h0, 1, 5'd7, 1, 32'h0, 32'h0, 32'h0, 0);
    chk("lw_mis_exc", exc_o, 1);

    run_txn(LW, 32'h200, 32'h0, 1, 5'd8, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, -1);
    chk("tmo_hold_exc", exc_o, 3);
    run_txn(LW, 32'h200, 32'h0, 1, 5'd8, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, int'(TO) - 1);
    chk("last_cycle_ack", wdata_o, 32'hDEAD_BEEF);

    // Reset mid-transaction, then a stray ack.
    @(negedge clk);
    in_valid = 1; mem_op = LW[3:0]; wdata = 32'h300; we = 1;
    @(negedge clk);
    in_valid = 0;
    chk("rstbus_req", bus_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; bus_ack = 1; bus_rdata = 32'h5555_AAAA;
    chk("rstbus_req_low", bus_req, 0);
    chk("rstbus_valid", out_valid, 0);
    chk("rstbus_ready", in_ready, 1);
    @(negedge clk);
    bus_ack = 0;
    chk("stray_valid", out_valid, 0);
    chk("stray_req", bus_req, 0);
    chk("stray_ready", in_ready, 1);

    for (int i = 0; i < 60; i++) begin
      int unsigned op = $urandom_range(0, 8);
      int unsigned r = $urandom_range(0, 7);
      logic [31:0] a = $urandom;
      int d = (r == 7) ? -1 : int'(r % 4);
      run_txn(op, a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom,
              $urandom, d);
      if ($urandom_range(0, 3) == 0) begin
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("idle_ack_valid", out_valid, 0);
        chk("idle_ack_req", bus_req, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_mem_lsu.md
STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of data bus.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for bus_ack (0 = no timeout).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid/in_ready  input/output  1/1  EX->MEM handshake; transfer when both high.
REQ-006 we, waddr, wdata  input  1/5/32  GPR write request; wdata = ALU result = effective address for memory ops.
REQ-007 mem_op  input  4  memory operation code (package enum).
REQ-008 store_data  input  32  rt value for stores.
REQ-009 we_hilo, hi, lo  input  1/32/32  HI/LO write request.
REQ-010 bus_req, bus_we, bus_addr, bus_be, bus_wdata  output  1/1/ADDR_W/4/32  data-bus request, word-aligned address.
REQ-011 bus_ack, bus_rdata  input  1/32  bus completion and read data (valid on ack).
REQ-012 out_valid, we_o, waddr_o, wdata_o, we_hilo_o, hi_o, lo_o  output  1/1/5/32/1/32/32  registered MEM->WB result.
REQ-013 exc_o  output  2  exception code valid with out_valid (NONE, ADEL, ADES, BUSERR).

Function
REQ-014 FSM states: IDLE, BUS; in_ready SHALL equal (state==IDLE).
REQ-015 Non-memory op accepted at cycle N SHALL appear on outputs at N+1 with out_valid=1, fields unchanged, exc_o=NONE.
REQ-016 out_valid SHALL be high for exactly one cycle per accepted instruction; outputs otherwise hold last values with out_valid=0, we_o=0, we_hilo_o=0.
REQ-017 Aligned memory op accepted at N: state->BUS at N+1, bus_req=1 from N+1 with addr/we/be/wdata stable until ack.
REQ-018 On bus_ack at cycle M in BUS: bus_req low at M+1, state->IDLE, result out_valid at M+1.
REQ-019 Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
REQ-020 Misaligned op: no bus transaction, out_valid at N+1 with we_o=0, we_hilo_o=0, exc_o=ADEL (load) or ADES (store).
REQ-021 Byte lanes little-endian: lane k = bits [8k+7:8k]; bus_addr = {addr[ADDR_W-1:2],2'b00}.
REQ-022 Stores: SB be=1<<addr[1:0], data replicated x4; SH be=3<<addr[1:0], data replicated x2; SW be=4'hF; we_o=0 on completion.
REQ-023 Loads: bus_be=4'hF, bus_we=0; LB/LH sign-extend, LBU/LHU zero-extend selected lane(s); LW full word; wdata_o=loaded value, we_o=input we.
REQ-024 we_hilo/hi/lo SHALL pass with the instruction unchanged, independent of mem_op.
REQ-025 Timeout counter cleared on entering BUS, increments each BUS cycle without ack; at TIMEOUT cycles without ack: drop bus_req, IDLE, out_valid with we_o=0, exc_o=BUSERR.
REQ-026 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (normal completion).
REQ-027 bus_ack while IDLE SHALL be ignored.

Reset
REQ-028 On rst: state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, all output registers 0, exc_o=NONE, counter=0.
REQ-029 rst during BUS SHALL abandon the transaction with no out_valid; a later stray ack SHALL be ignored.

Structure
REQ-030 Package mem_pkg SHALL hold mem_op enum (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW), exc code enum, and lane/alignment constants.
REQ-031 One sub-module, lsu_lane_align: combinational byte-enable generation, store replication and load extraction/extension.

Verification
REQ-032 ALU op we=1 waddr=3 wdata=0x1234 -> next cycle out_valid=1, wdata_o=0x1234, exc_o=NONE.
REQ-033 LB addr=0x103, ack after 2 cycles with rdata=0x80FF_0000 -> wdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 SH addr=0x102 store_data=0xABCD -> bus_addr=0x100, bus_be=4'hC, bus_wdata=0xABCD_ABCD, bus_we=1, we_o=0 on completion.
REQ-035 LW addr=0x101 -> no bus_req, out_valid next cycle, exc_o=ADEL, we_o=0.
REQ-036 TIMEOUT=4, no ack -> bus_req high 4 cycles, then out_valid, exc_o=BUSERR; repeat with ack on 4th cycle -> normal result.
REQ-037 rst asserted in BUS, ack one cycle after -> bus_req=0, no out_valid, in_ready=1.
